// File: rtl/instr_decode_stage.sv
// Registered instruction-decode stage: splits fetch words into fields and control,
// queues the decoded bundle in a 2-entry skid buffer, and counts illegal opcodes.
module instr_decode_stage #(
    parameter int INSTR_W = 32,
    parameter int OPC_W   = 6,
    parameter int REG_AW  = 5,
    parameter int IMM_W   = 16,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_class,
    output logic [3:0]         out_alu_op,
    output logic               out_we,
    output logic [REG_AW-1:0]  out_wreg,
    output logic [REG_AW-1:0]  out_rs2,
    output logic [REG_AW-1:0]  out_rs1,
    output logic [IMM_W-1:0]   out_imm,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   illegal_count
);

    localparam int RD2_LSB     = INSTR_W - OPC_W - REG_AW;
    localparam int RD1_LSB     = RD2_LSB - REG_AW;
    localparam int ST_ADDR_LSB = INSTR_W - OPC_W - ADDR_W;

    // Opcode 16 must be encodable for the top ALU function to exist.
    if ((INSTR_W < OPC_W + 4 * REG_AW) || (IMM_W > INSTR_W - OPC_W) ||
        (ADDR_W > INSTR_W - OPC_W) || (OPC_W < 5)) begin : g_param_check
        $error("instr_decode_stage: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        CLS_MOVI    = 3'd0,
        CLS_MOVR    = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_ALU     = 3'd4,
        CLS_ILLEGAL = 3'd7
    } instr_class_e;

    typedef struct packed {
        instr_class_e      cls;
        logic [3:0]        alu_op;
        logic              we;
        logic [REG_AW-1:0] wreg;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rs1;
        logic [IMM_W-1:0]  imm;
        logic [ADDR_W-1:0] addr;
        logic              illegal;
    } bundle_t;

    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd2;
    logic [REG_AW-1:0] rd1;
    bundle_t           dec;

    assign opcode = in_instr[INSTR_W-1 -: OPC_W];
    assign rd2    = in_instr[RD2_LSB +: REG_AW];
    assign rd1    = in_instr[RD1_LSB +: REG_AW];

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a latch.
        dec         = '0;
        dec.rs2     = in_instr[2*REG_AW-1:REG_AW];
        dec.rs1     = in_instr[REG_AW-1:0];
        dec.imm     = in_instr[IMM_W-1:0];
        if (opcode == OPC_W'(0)) begin
            dec.cls  = CLS_MOVI;
            dec.we   = 1'b1;
            dec.wreg = rd2;
        end else if (opcode == OPC_W'(1)) begin
            dec.cls  = CLS_MOVR;
            dec.we   = 1'b1;
            dec.wreg = rd2;
        end else if (opcode == OPC_W'(2)) begin
            dec.cls  = CLS_LOAD;
            dec.we   = 1'b1;
            dec.wreg = rd2;
            dec.addr = in_instr[ADDR_W-1:0];
        end else if (opcode == OPC_W'(3)) begin
            dec.cls  = CLS_STORE;
            dec.addr = in_instr[ST_ADDR_LSB +: ADDR_W];
        end else if (opcode <= OPC_W'(16)) begin
            dec.cls    = CLS_ALU;
            dec.we     = 1'b1;
            dec.wreg   = rd1;
            dec.alu_op = 4'(opcode - OPC_W'(4));
        end else begin
            dec.cls     = CLS_ILLEGAL;
            dec.illegal = 1'b1;
        end
    end

    bundle_t    buf_q [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       accept;
    logic       consume;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid & in_ready & ~flush;
    assign consume   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffer entries are reset because out_* must read zero out of reset.
            for (int i = 0; i < 2; i++) buf_q[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking updates let pointers and count all see pre-edge values.
            if (accept) begin
                buf_q[wr_ptr] <= dec;
                wr_ptr        <= ~wr_ptr;
            end
            if (consume) rd_ptr <= ~rd_ptr;
            case ({accept, consume})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_count <= '0;
        end else if (accept && dec.illegal && (illegal_count != '1)) begin
            illegal_count <= illegal_count + CNT_W'(1);
        end
    end

    bundle_t head;
    assign head        = buf_q[rd_ptr];
    assign out_class   = head.cls;
    assign out_alu_op  = head.alu_op;
    assign out_we      = head.we;
    assign out_wreg    = head.wreg;
    assign out_rs2     = head.rs2;
    assign out_rs1     = head.rs1;
    assign out_imm     = head.imm;
    assign out_addr    = head.addr;
    assign out_illegal = head.illegal;

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
Parametrised, registered instruction-decode stage for the 16-bit Harvard core.
- Accepts 32-bit instruction words from fetch over a valid/ready handshake.
- Splits each word into opcode, register, immediate and address fields, and produces a decoded control bundle: instruction class, ALU op, write enable and write register.
- Buffers the bundle in a 2-entry skid buffer toward execute, and flags and counts illegal opcodes.

Parameters:
INSTR_W, 32, instruction word width
OPC_W, 6, opcode width, at [INSTR_W-1 -: OPC_W]
REG_AW, 5, register-specifier width
IMM_W, 16, immediate width, at [IMM_W-1:0]
ADDR_W, 8, data-memory address width
CNT_W, 16, illegal-opcode counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous discard of buffered and in-flight instructions
in_valid  in  1  fetch presents in_instr
in_ready  out  1  stage can accept an instruction
in_instr  in  INSTR_W  instruction word
out_valid  out  1  decoded bundle available
out_ready  in  1  execute consumes bundle
out_class  out  3  0 MOVI, 1 MOVR, 2 LOAD, 3 STORE, 4 ALU, 7 ILLEGAL
out_alu_op  out  4  ALU function (ALU class only, else 0)
out_we  out  1  register-file write enable
out_wreg  out  REG_AW  write register
out_rs2  out  REG_AW  field [2*REG_AW-1:REG_AW]
out_rs1  out  REG_AW  field [REG_AW-1:0]
out_imm  out  IMM_W  field [IMM_W-1:0]
out_addr  out  ADDR_W  memory address
out_illegal  out  1  opcode undefined
illegal_count  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset (async, any time, including mid-transfer):
  - buffer count = 0, out_valid = 0, in_ready = 1.
  - All out_* data = 0 and illegal_count = 0.
- Field positions:
  - rd2 = [INSTR_W-OPC_W-1 -: REG_AW] ([25:21] at default).
  - rd1 = next REG_AW bits below rd2 ([20:16]).
- Opcode map:
  - 0 MOVI: wreg=rd2, we=1, uses imm.
  - 1 MOVR: wreg=rd2, we=1, source=rs1.
  - 2 LOAD: wreg=rd2, we=1, addr=[ADDR_W-1:0].
  - 3 STORE: we=0, wreg=0, addr=[INSTR_W-OPC_W-1 -: ADDR_W] ([25:18]), data reg=rs1.
  - 4..16 ALU: wreg=rd1, we=1, alu_op = opcode-4. Encodings: ADD0 SUB1 NEG2 MUL3 AND4 OR5 XOR6 NAND7 NOR8 XNOR9 NOT10 SHL11 SHR12.
  - 17..2^OPC_W-1: class 7, out_illegal=1, we=0, alu_op=0, wreg=0. Raw fields still presented.
- Handshake:
  - Accept when in_valid & in_ready & !flush.
  - Consume when out_valid & out_ready.
  - Decode is combinational on in_instr; the result is written into the buffer on accept.
  - Latency: accepted in cycle N, visible on out_* in cycle N+1.
  - in_ready = (count != 2). It is registered state only; there is no combinational path from out_ready.
  - out_valid = (count != 0). out_* always reflect the head entry and hold stable while out_valid & !out_ready.
- Buffer:
  - Strict FIFO order.
  - Simultaneous accept and consume with count=1: count stays 1; the new entry becomes head next cycle.
  - With count=2 no accept is possible, but consume proceeds.
  - With count=0 and out_ready=1, the accepted entry still waits 1 cycle; there is no bypass.
- Flush:
  - Count forced to 0 next cycle; out_valid = 0.
  - Any same-cycle accept is dropped and not counted.
  - A same-cycle consume is treated as completed.
- illegal_count:
  - +1 per accepted illegal instruction.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Unaffected by flush; cleared only by reset.
- Parameter legality: INSTR_W ≥ OPC_W+2*REG_AW+2*REG_AW and IMM_W, ADDR_W ≤ INSTR_W-OPC_W. Otherwise elaboration error.

Test Plan:
- ADD 0x10030041, out_ready=1 → next cycle out_valid=1, class 4, alu_op 0, we 1, wreg 3, rs2 2, rs1 1.
- MOVI 0x00A01234, then STORE 0x0EAC0007, back-to-back:
  - MOVI → class 0, wreg 5, imm 0x1234.
  - STORE → class 3, we 0, addr 0xAB, rs1 7.
  - Two consecutive output cycles.
- out_ready=0, offer 3 instructions → first two accepted, in_ready=0 from the cycle after the second accept. Raise out_ready → the three emerge in order, one per cycle, and in_ready returns to 1.
- 0xFC000000 (opcode 63) → class 7, out_illegal 1, we 0, illegal_count 1. Then 2^16 more illegal accepts → count holds 0xFFFF.
- Two entries buffered, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, dropped entry not counted.
- Assert rst_n=0 asynchronously mid-stream with count=2 → outputs and count zero immediately. Release → first accept appears after 1 cycle.
